sb_rr_bus: RTL and testbench

- Parametrised multi-host, multi-device interconnect for the simple-system SoC; successor to the fixed-priority single-host bus.
- Adds round-robin arbitration across NrHosts, variable device response latency (one outstanding transaction), and decode-error responses for unmapped addresses.
- Sits between the Ibex data port, extra bus hosts (DMA, debug) and the RAM, simulator-control and timer devices.

---
 rtl/sb_bus_pkg.sv | 27 ++
 rtl/sb_rr_arbiter.sv | 40 ++++
 rtl/sb_rr_bus.sv | 208 ++++++++++++++++++++
 tb/tb_sb_rr_bus.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_bus_pkg.sv
// Shared types and helpers for the round-robin system bus.
//   bus_state_e  : bus FSM states (idle / one transaction outstanding)
//   resp_trk_t   : response-tracking record captured on each grant
//   clog2_min1   : index width helper that never returns zero
// Index fields in resp_trk_t are sized for the largest supported
// configuration (8 hosts, 16 devices); narrower indices are zero-extended.
package sb_bus_pkg;

    localparam int MaxHostIdxW = 3;
    localparam int MaxDevIdxW  = 4;

    typedef enum logic {
        BusIdle = 1'b0,
        BusBusy = 1'b1
    } bus_state_e;

    typedef struct packed {
        logic [MaxHostIdxW-1:0] host_idx;
        logic [MaxDevIdxW-1:0]  dev_idx;
        logic                   dec_err;
    } resp_trk_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : per-requester request vector
//   ptr : index that has highest priority this cycle (must be < N)
//   gnt : one-hot grant, all zero when nothing requests
//   idx : binary index of the granted requester (0 when no grant)
module sb_rr_arbiter
    import sb_bus_pkg::*;
#(
    parameter int N = 2,
    localparam int IdxW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);

    logic            found;
    logic [IdxW:0]   pos;

    // Walk the requesters starting at ptr, wrapping at N; first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IdxW+1)'(k);
            if (pos >= (IdxW+1)'(N)) begin
                pos = pos - (IdxW+1)'(N);
            end
            if (!found && req[pos[IdxW-1:0]]) begin
                found                = 1'b1;
                gnt[pos[IdxW-1:0]]   = 1'b1;
                idx                  = pos[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/sb_rr_bus.sv
// Multi-host, multi-device system bus with round-robin arbitration and a
// single outstanding transaction.
//   host_*    : per-host request/grant and response channels (packed vectors)
//   device_*  : one-hot device request, broadcast request fields, responses
//   cfg_*     : per-device base/mask address decode configuration
// A request is accepted in the cycle host_gnt_o[h] is high (req & gnt). The
// matching response is the single cycle host_rvalid_o[h] is high; host_rdata_o
// and host_err_o are meaningful only in that cycle and are zero otherwise.
// Optional macro SB_BUS_PERF_CNT_EN adds per-host saturating grant and wait
// counters (perf_grant_cnt_o, perf_wait_cnt_o).
module sb_rr_bus
    import sb_bus_pkg::*;
#(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 3,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrHosts-1:0]              host_req_i,
    output logic [NrHosts-1:0]              host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0]              host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]  host_be_i,
    input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]              host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]    host_rdata_o,
    output logic [NrHosts-1:0]              host_err_o,
    output logic [NrDevices-1:0]            device_req_o,
    output logic [AddressWidth-1:0]         device_addr_o,
    output logic                            device_we_o,
    output logic [DataWidth/8-1:0]          device_be_o,
    output logic [DataWidth-1:0]            device_wdata_o,
    input  logic [NrDevices-1:0]            device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]  device_rdata_i,
    input  logic [NrDevices-1:0]            device_err_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
`ifdef SB_BUS_PERF_CNT_EN
    ,
    output logic [NrHosts*32-1:0]           perf_grant_cnt_o,
    output logic [NrHosts*32-1:0]           perf_wait_cnt_o
`endif
);

    localparam int HostIdxW = clog2_min1(NrHosts);
    localparam int DevIdxW  = clog2_min1(NrDevices);
    localparam int BeW      = DataWidth / 8;

    bus_state_e            state_q;
    resp_trk_t             trk_q;
    logic [HostIdxW-1:0]   rr_q;
    logic [HostIdxW-1:0]   rr_nxt;
    logic [HostIdxW:0]     rr_inc;

    logic                  rsp_valid;
    logic [DataWidth-1:0]  rsp_rdata;
    logic                  rsp_err;
    logic                  complete;
    logic                  can_grant;
    logic                  any_gnt;
    logic [NrHosts-1:0]    arb_req;
    logic [NrHosts-1:0]    gnt;
    logic [HostIdxW-1:0]   gnt_idx;

    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeW-1:0]          sel_be;
    logic [DataWidth-1:0]    sel_wdata;
    logic                    dec_hit;
    logic [DevIdxW-1:0]      dec_idx;

    // Response of the outstanding transaction. A decode error completes on
    // its own in the first busy cycle; rvalid from any other device is ignored.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (trk_q.dec_err) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
        end else begin
            for (int d = 0; d < NrDevices; d++) begin
                if (trk_q.dev_idx == MaxDevIdxW'(d)) begin
                    rsp_valid = device_rvalid_i[d];
                    rsp_rdata = device_rdata_i[d*DataWidth +: DataWidth];
                    rsp_err   = device_err_i[d];
                end
            end
        end
    end

    assign complete  = !rst_i && (state_q == BusBusy) && rsp_valid;
    assign can_grant = !rst_i && ((state_q == BusIdle) || complete);
    assign arb_req   = host_req_i & {NrHosts{can_grant}};
    assign any_gnt   = |gnt;

    sb_rr_arbiter #(
        .N (NrHosts)
    ) u_arb (
        .req (arb_req),
        .ptr (rr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Granted host's request fields; all zero when nothing is granted.
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (gnt[h]) begin
                sel_addr  = host_addr_i[h*AddressWidth +: AddressWidth];
                sel_we    = host_we_i[h];
                sel_be    = host_be_i[h*BeW +: BeW];
                sel_wdata = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
    end

    // Descending scan so the lowest matching device index is left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((sel_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth])
                == cfg_device_addr_base_i[d*AddressWidth +: AddressWidth]) begin
                dec_hit = 1'b1;
                dec_idx = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        device_req_o = '0;
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d] = any_gnt && dec_hit && (dec_idx == DevIdxW'(d));
        end
    end

    assign host_gnt_o     = gnt;
    assign device_addr_o  = sel_addr;
    assign device_we_o    = sel_we;
    assign device_be_o    = sel_be;
    assign device_wdata_o = sel_wdata;

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (complete && (trk_q.host_idx == MaxHostIdxW'(h))) begin
                host_rvalid_o[h]                       = 1'b1;
                host_err_o[h]                          = rsp_err;
                host_rdata_o[h*DataWidth +: DataWidth] = rsp_rdata;
            end
        end
    end

    // Pointer moves to the host after the one just granted, wrapping at NrHosts.
    always_comb begin
        rr_inc = {1'b0, gnt_idx} + (HostIdxW+1)'(1);
        if (rr_inc >= (HostIdxW+1)'(NrHosts)) begin
            rr_inc = rr_inc - (HostIdxW+1)'(NrHosts);
        end
        rr_nxt = rr_inc[HostIdxW-1:0];
    end

    // Bus FSM. A grant always (re)enters BUSY, which covers back-to-back
    // transactions where completion and the next grant share a cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BusIdle;
            rr_q    <= '0;
            trk_q   <= '0;
        end else if (any_gnt) begin
            state_q        <= BusBusy;
            rr_q           <= rr_nxt;
            trk_q.host_idx <= MaxHostIdxW'(gnt_idx);
            trk_q.dev_idx  <= MaxDevIdxW'(dec_idx);
            trk_q.dec_err  <= !dec_hit;
        end else if (complete) begin
            state_q <= BusIdle;
        end
    end

`ifdef SB_BUS_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_grant_cnt_o <= '0;
            perf_wait_cnt_o  <= '0;
        end else begin
            for (int h = 0; h < NrHosts; h++) begin
                if (gnt[h] && (perf_grant_cnt_o[h*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_grant_cnt_o[h*32 +: 32] <= perf_grant_cnt_o[h*32 +: 32] + 32'd1;
                end
                if (host_req_i[h] && !gnt[h] && (perf_wait_cnt_o[h*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_wait_cnt_o[h*32 +: 32] <= perf_wait_cnt_o[h*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sb_rr_bus.sv
// Testbench for sb_rr_bus (2 hosts; RAM, sim-control and timer devices).
// Compile with SB_BUS_PERF_CNT_EN defined to also cover the perf counters.
module tb_sb_rr_bus;

  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NH-1:0]    host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [NH*AW-1:0] host_addr;
  logic [NH*BW-1:0] host_be;
  logic [NH*DW-1:0] host_wdata, host_rdata;
  logic [ND-1:0]    device_req, device_rvalid, device_err;
  logic [AW-1:0]    device_addr;
  logic             device_we;
  logic [BW-1:0]    device_be;
  logic [DW-1:0]    device_wdata;
  logic [ND*DW-1:0] device_rdata;
  logic [ND*AW-1:0] cfg_base, cfg_mask;
`ifdef SB_BUS_PERF_CNT_EN
  logic [NH*32-1:0] perf_grant_cnt, perf_wait_cnt;
`endif

  sb_rr_bus #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(device_req), .device_addr_o(device_addr), .device_we_o(device_we),
    .device_be_o(device_be), .device_wdata_o(device_wdata),
    .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata), .device_err_i(device_err),
    .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
`ifdef SB_BUS_PERF_CNT_EN
    , .perf_grant_cnt_o(perf_grant_cnt), .perf_wait_cnt_o(perf_wait_cnt)
`endif
  );

  // Memory map: RAM, sim-control (inside the timer window), timer.
  logic [AW-1:0] base_a [ND];
  logic [AW-1:0] mask_a [ND];

  // ---------------- scoreboard / reference model ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [NH-1:0] exp_q [$];

  int m_rr = 0, m_host = 0, m_dev = 0;
  bit m_busy = 0, m_decerr = 0;
  int unsigned m_gcnt [NH];
  int unsigned m_wcnt [NH];

  int lat [ND];
  int cnt [ND];
  bit spur_en = 0;

  logic [NH-1:0] obs_gnt, obs_rvalid, obs_err;
  logic [ND-1:0] obs_dreq;
  logic [NH*DW-1:0] obs_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++) begin
      if ((a & mask_a[d]) == base_a[d]) return d;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_host(input int h, input bit req, input logic [AW-1:0] addr);
    host_req[h]            = req;
    host_addr[h*AW +: AW]  = addr;
    host_we[h]             = 1'($urandom_range(0, 1));
    host_be[h*BW +: BW]    = BW'($urandom());
    host_wdata[h*DW +: DW] = $urandom();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'h0010_0000 | ($urandom() & 32'h000F_FFFC);
      1: return 32'h0002_0000 | ($urandom() & 32'h0000_03FC);
      2: return 32'h0002_0000 | ($urandom() & 32'h0001_FFFC);
      3: return 32'h0000_5000;
      default: return $urandom();
    endcase
  endfunction

  // One bus cycle: drive device responses, check every DUT output against
  // the transaction-level model, then advance model and device latencies.
  task automatic step();
    logic [NH-1:0] eg, erv, eerr;
    logic [ND-1:0] edr;
    logic [AW-1:0] ea;
    logic ewe;
    logic [BW-1:0] ebe;
    logic [DW-1:0] ewd;
    logic [NH*DW-1:0] erd;
    logic [NH*32-1:0] egc, ewc;
    bit complete, can;
    int gh, dd, h;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      device_rvalid[d] = (cnt[d] == 1) ||
                         (spur_en && cnt[d] == 0 && !(m_busy && !m_decerr && m_dev == d) &&
                          $urandom_range(0, 5) == 0);
      device_rdata[d*DW +: DW] = $urandom();
      device_err[d] = ($urandom_range(0, 3) == 0);
    end
    #1;
    complete = m_busy && (m_decerr || device_rvalid[m_dev]);
    can = !rst && (!m_busy || complete);
    gh = -1; dd = -1;
    eg = '0; edr = '0; ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
    if (can) begin
      for (int k = 0; k < NH; k++) begin
        h = (m_rr + k) % NH;
        if (gh < 0 && host_req[h]) gh = h;
      end
    end
    if (gh >= 0) begin
      eg[gh] = 1'b1;
      ea  = host_addr[gh*AW +: AW];
      ewe = host_we[gh];
      ebe = host_be[gh*BW +: BW];
      ewd = host_wdata[gh*DW +: DW];
      dd  = decode(ea);
      if (dd >= 0) edr[dd] = 1'b1;
    end
    erv = '0; eerr = '0; erd = '0;
    if (complete && !rst) begin
      erv[m_host] = 1'b1;
      if (m_decerr) eerr[m_host] = 1'b1;
      else begin
        eerr[m_host] = device_err[m_dev];
        erd[m_host*DW +: DW] = device_rdata[m_dev*DW +: DW];
      end
    end
    chk("host_gnt", host_gnt, eg);
    chk("device_req", device_req, edr);
    chk("device_addr", device_addr, ea);
    chk("device_we", device_we, ewe);
    chk("device_be", device_be, ebe);
    chk("device_wdata", device_wdata, ewd);
    chk("host_rvalid", host_rvalid, erv);
    chk("host_err", host_err, eerr);
    chk("host_rdata", host_rdata, erd);
    for (int i = 0; i < NH; i++) begin
      egc[i*32 +: 32] = m_gcnt[i];
      ewc[i*32 +: 32] = m_wcnt[i];
    end
`ifdef SB_BUS_PERF_CNT_EN
    chk("perf_grant_cnt", perf_grant_cnt, egc);
    chk("perf_wait_cnt", perf_wait_cnt, ewc);
`endif
    obs_gnt = host_gnt; obs_dreq = device_req; obs_rvalid = host_rvalid;
    obs_err = host_err; obs_rdata = host_rdata;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_rr = 0; m_host = 0; m_dev = 0; m_decerr = 0;
      for (int i = 0; i < NH; i++) begin m_gcnt[i] = 0; m_wcnt[i] = 0; end
    end else begin
      if (gh >= 0) begin
        m_busy = 1; m_host = gh; m_decerr = (dd < 0); m_dev = (dd < 0) ? 0 : dd;
        m_rr = (gh + 1) % NH;
      end else if (complete) begin
        m_busy = 0;
      end
      for (int i = 0; i < NH; i++) begin
        if (eg[i] && m_gcnt[i] != 32'hFFFF_FFFF) m_gcnt[i]++;
        if (host_req[i] && !eg[i] && m_wcnt[i] != 32'hFFFF_FFFF) m_wcnt[i]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (cnt[d] > 0) cnt[d]--;
      if (obs_dreq[d]) cnt[d] = lat[d];
    end
    #1;
  endtask

  task automatic idle_hosts();
    set_host(0, 0, 32'h0);
    set_host(1, 0, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NH-1:0] prev_gnt;
    base_a = '{32'h0010_0000, 32'h0002_0000, 32'h0002_0000};
    mask_a = '{32'hFFF0_0000, 32'hFFFF_FC00, 32'hFFFE_0000};
    for (int d = 0; d < ND; d++) begin
      cfg_base[d*AW +: AW] = base_a[d];
      cfg_mask[d*AW +: AW] = mask_a[d];
      cnt[d] = 0;
    end
    lat = '{1, 1, 3};
    for (int i = 0; i < NH; i++) begin m_gcnt[i] = 0; m_wcnt[i] = 0; end
    host_req = '0; host_addr = '0; host_we = '0; host_be = '0; host_wdata = '0;
    device_rvalid = '0; device_rdata = '0; device_err = '0;

    // Reset: everything quiet, even with a request pending.
    rst = 1'b1;
    step();
    set_host(1, 1, 32'h0010_0000);
    step();
    chk("reset_gnt", obs_gnt, 2'b00);
    rst = 1'b0;
    idle_hosts();

    // Both hosts hammer RAM: grants alternate, responses follow back-to-back.
    for (int k = 0; k < 8; k++) exp_q.push_back((k % 2) ? 2'b10 : 2'b01);
    prev_gnt = '0;
    for (int k = 0; k < 8; k++) begin
      set_host(0, 1, 32'h0010_0000 | (($urandom() & 32'hFF) << 2));
      set_host(1, 1, 32'h0010_0000 | (($urandom() & 32'hFF) << 2));
      step();
      chk("rr_alternate", obs_gnt, exp_q.pop_front());
      if (k > 0) chk("b2b_rvalid", obs_rvalid, prev_gnt);
      prev_gnt = obs_gnt;
    end
    idle_hosts();
    step();

    // Unmapped address from H1: decode error one cycle later.
    set_host(1, 1, 32'h0000_5000);
    step();
    chk("decerr_gnt", obs_gnt, 2'b10);
    chk("decerr_no_dreq", obs_dreq, 3'b000);
    idle_hosts();
    step();
    chk("decerr_rvalid", obs_rvalid, 2'b10);
    chk("decerr_err", obs_err, 2'b10);
    chk("decerr_rdata", obs_rdata, 64'h0);

    // Slow timer access by H0 stalls H1 until completion.
    set_host(0, 1, 32'h0003_0004);
    set_host(1, 1, 32'h0010_0040);
    step();
    chk("timer_gnt", obs_gnt, 2'b01);
    chk("timer_dreq", obs_dreq, 3'b100);
    set_host(0, 0, 32'h0);
    step();
    chk("stall_gnt1", obs_gnt, 2'b00);
    step();
    chk("stall_gnt2", obs_gnt, 2'b00);
    step();
    chk("timer_done_rvalid", obs_rvalid, 2'b01);
    chk("h1_gnt_on_done", obs_gnt, 2'b10);
    idle_hosts();
    step();

    // Overlapping decode windows: lowest index wins.
    set_host(0, 1, 32'h0002_0010);
    step();
    chk("overlap_dreq", obs_dreq, 3'b010);
    idle_hosts();
    step();

    // Reset during BUSY; the late device response must be dropped.
    lat[2] = 2;
    set_host(0, 1, 32'h0003_0004);
    step();
    chk("pre_reset_gnt", obs_gnt, 2'b01);
    set_host(0, 0, 32'h0);
    set_host(1, 1, 32'h0010_0000);
    rst = 1'b1;
    step();
    chk("in_reset_gnt", obs_gnt, 2'b00);
    rst = 1'b0;
    set_host(0, 1, 32'h0010_0004);
    set_host(1, 1, 32'h0010_0008);
    step();
    chk("late_rvalid_dropped", obs_rvalid, 2'b00);
    chk("post_reset_gnt_h0", obs_gnt, 2'b01);
    idle_hosts();
    step();

    // Perf counters: H0 makes five grants, H1 waits four cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lat[2] = 5;
    for (int c = 0; c < 4; c++) begin
      set_host(0, 1, 32'h0010_0000 | (c << 2));
      step();
    end
    set_host(0, 1, 32'h0003_0000);
    step();
    set_host(0, 0, 32'h0);
    set_host(1, 1, 32'h0010_0100);
    for (int c = 0; c < 5; c++) step();
    chk("perf_h1_gnt", obs_gnt, 2'b10);
`ifdef SB_BUS_PERF_CNT_EN
    chk("perf_grant_h0", perf_grant_cnt[31:0], 32'd5);
    chk("perf_wait_h1", perf_wait_cnt[63:32], 32'd4);
`endif
    idle_hosts();
    step();

    // Randomized traffic with spurious device responses and sporadic reset.
    spur_en = 1;
    for (int d = 0; d < ND; d++) lat[d] = $urandom_range(1, 4);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int h = 0; h < NH; h++) set_host(h, ($urandom_range(0, 9) < 6), rand_addr());
      step();
    end
    spur_en = 0;
    rst = 1'b0;
    idle_hosts();
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
